// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Parametrised registered ALU with valid/ready handshakes on both sides.
//   ADD, SUB, MUL and the logic ops finish in one cycle. DIV uses an iterative
//   restoring divider that produces one quotient bit per cycle, MSB first.
//   The result register holds a single entry. A new request is accepted only
//   when that entry is empty or is being consumed in the same cycle.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//   BAD_VALUE  result returned for unsupported op codes (truncated to WIDTH)
//
// Optional feature
//   ALU_PIPE_SAT_EN  when defined, op 0100 is an unsigned saturating add and
//                    op 0101 is an unsigned saturating subtract. When it is
//                    not defined, both codes are treated as unsupported.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request valid            in_ready   request can be accepted
//   a, b       operands                 op         operation select
//   out_valid  result valid             out_ready  consumer accepts result
//   result     result value             carry      carry/borrow/overflow
//   zero       result == 0              err        div-by-zero / bad op
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BAD_VALUE = 32'h0000_00AC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
`ifdef ALU_PIPE_SAT_EN
  localparam logic [3:0] OP_SADD = 4'b0100;
  localparam logic [3:0] OP_SSUB = 4'b0101;
`endif
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;

  localparam logic [WIDTH-1:0] BAD_RESULT = BAD_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS  = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  // Architectural state
  state_t           state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             zero_r;
  logic             err_r;

  // Divider state: partial remainder, quotient/dividend shift register,
  // latched divisor and remaining-step counter.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] divisor_r;
  logic [CW-1:0]    count_r;

  // Combinational helpers
  logic               accept_s;
  logic               start_div_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   alu_result_s;
  logic               alu_carry_s;
  logic               alu_err_s;
  logic [WIDTH:0]     rem_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quot_next_s;

  // A request may be taken only in IDLE when the output slot is free or
  // draining this cycle, so single-cycle ops can stream at one per clock.
  assign in_ready    = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready;
  assign start_div_s = (op == OP_DIV) && (b != ALL_ZEROS);

  // The top bit of the (WIDTH+1)-bit difference is set exactly when a < b.
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign prod_s = {ALL_ZEROS, a} * {ALL_ZEROS, b};

  // Single-cycle ALU result, flags and error for the op being offered.
  always_comb begin
    alu_result_s = BAD_RESULT;
    alu_carry_s  = 1'b0;
    alu_err_s    = 1'b1;
    case (op)
      OP_ADD: begin
        alu_result_s = sum_s[WIDTH-1:0];
        alu_carry_s  = sum_s[WIDTH];
        alu_err_s    = 1'b0;
      end
      OP_SUB: begin
        alu_result_s = diff_s[WIDTH-1:0];
        alu_carry_s  = diff_s[WIDTH];
        alu_err_s    = 1'b0;
      end
      OP_MUL: begin
        alu_result_s = prod_s[WIDTH-1:0];
        alu_carry_s  = |prod_s[2*WIDTH-1:WIDTH];
        alu_err_s    = 1'b0;
      end
      OP_DIV: begin
        // Only the divide-by-zero case completes here; b != 0 goes to the
        // iterative divider instead.
        alu_result_s = ALL_ONES;
        alu_carry_s  = 1'b0;
        alu_err_s    = 1'b1;
      end
`ifdef ALU_PIPE_SAT_EN
      OP_SADD: begin
        alu_result_s = sum_s[WIDTH] ? ALL_ONES : sum_s[WIDTH-1:0];
        alu_carry_s  = sum_s[WIDTH];
        alu_err_s    = 1'b0;
      end
      OP_SSUB: begin
        alu_result_s = diff_s[WIDTH] ? ALL_ZEROS : diff_s[WIDTH-1:0];
        alu_carry_s  = diff_s[WIDTH];
        alu_err_s    = 1'b0;
      end
`endif
      OP_AND: begin
        alu_result_s = a & b;
        alu_carry_s  = 1'b0;
        alu_err_s    = 1'b0;
      end
      OP_OR: begin
        alu_result_s = a | b;
        alu_carry_s  = 1'b0;
        alu_err_s    = 1'b0;
      end
      OP_XOR: begin
        alu_result_s = a ^ b;
        alu_carry_s  = 1'b0;
        alu_err_s    = 1'b0;
      end
      default: begin
        alu_result_s = BAD_RESULT;
        alu_carry_s  = 1'b0;
        alu_err_s    = 1'b1;
      end
    endcase
  end

  // One restoring-division step. The next dividend bit is shifted into the
  // remainder, and the divisor is subtracted when it fits. The true
  // difference is always below the divisor, so a WIDTH-bit subtraction is
  // exact.
  always_comb begin
    rem_shift_s = {rem_r, quot_r[WIDTH-1]};
    div_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
    rem_next_s  = div_ge_s ? (rem_shift_s[WIDTH-1:0] - divisor_r)
                           : rem_shift_s[WIDTH-1:0];
    quot_next_s = {quot_r[WIDTH-2:0], div_ge_s};
  end

  // Control FSM, divider datapath and the single-entry output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= ALL_ZEROS;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      rem_r       <= ALL_ZEROS;
      quot_r      <= ALL_ZEROS;
      divisor_r   <= ALL_ZEROS;
      count_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (start_div_s) begin
              // The slot is empty or draining on acceptance, so it is free
              // for the whole divide.
              rem_r       <= ALL_ZEROS;
              quot_r      <= a;
              divisor_r   <= b;
              count_r     <= CW'(WIDTH - 1);
              out_valid_r <= 1'b0;
              state_r     <= ST_DIV;
            end else begin
              result_r    <= alu_result_s;
              carry_r     <= alu_carry_s;
              zero_r      <= (alu_result_s == ALL_ZEROS);
              err_r       <= alu_err_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_IDLE;
            end
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_DIV: begin
          rem_r  <= rem_next_s;
          quot_r <= quot_next_s;
          if (count_r == {CW{1'b0}}) begin
            result_r    <= quot_next_s;
            carry_r     <= 1'b0;
            zero_r      <= (quot_next_s == ALL_ZEROS);
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            count_r <= count_r - CW'(1);
            if (out_valid_r && out_ready) begin
              out_valid_r <= 1'b0;
            end else begin
              out_valid_r <= out_valid_r;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Self-checking bench for alu_pipe at WIDTH=8. When a request is driven, the
//   bench pushes the model's expected result onto a queue. A monitor pops and
//   compares that entry each time a result transfers. Directed sections also
//   check latency, stall holding and reset behaviour. The model honours
//   ALU_PIPE_SAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         err;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   w;

  alu_pipe #(.WIDTH(W), .BAD_VALUE(32'h0000_00AC)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int xi;
    int yi;
    int s;
    xi = int'(x);
    yi = int'(y);
    e  = '0;
    case (o)
      4'h0: begin s = xi + yi; e.res = s[7:0]; e.c = (s > 255); end
      4'h1: begin s = xi - yi; e.res = s[7:0]; e.c = (xi < yi); end
      4'h2: begin s = xi * yi; e.res = s[7:0]; e.c = (s > 255); end
      4'h3: begin
        if (yi == 0) begin e.res = 8'hFF; e.e = 1'b1; end
        else         begin s = xi / yi; e.res = s[7:0]; end
      end
`ifdef ALU_PIPE_SAT_EN
      4'h4: begin s = xi + yi; e.res = (s > 255) ? 8'hFF : s[7:0]; e.c = (s > 255); end
      4'h5: begin s = xi - yi; e.res = (xi < yi) ? 8'h00 : s[7:0]; e.c = (xi < yi); end
`endif
      4'h6: e.res = x & y;
      4'h7: e.res = x | y;
      4'h8: e.res = x ^ y;
      default: begin e.res = 8'hAC; e.e = 1'b1; end
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Drive one request from posedge+1 and push its expectation. Return after
  // the accepting edge, at posedge+1. When the request is held off, release
  // any stalled result so that progress is always made.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, output int waits);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(model(o, x, y));
    waits = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check_eq("accept_timeout", 64'(waits), 64'd0);
        break;
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    a  = ~x;
    b  = ~y;
    op = 4'hF;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: compare each transferring result with the oldest
  // expectation.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("result", 64'(result), 64'(mon_e.res));
        check_eq("carry",  64'(carry),  64'(mon_e.c));
        check_eq("zero",   64'(zero),   64'(mon_e.z));
        check_eq("err",    64'(err),    64'(mon_e.e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, expected $finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = 4'h0;
    out_ready = 1'b1;
    #12;
    check_eq("reset_state", 64'({out_valid, result, carry, zero, err}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("in_ready_after_reset", 64'(in_ready), 64'd1);

    // ADD with carry out; in_ready stays high while out_ready is high.
    send(4'h0, 8'hF0, 8'h20, w);
    @(negedge clock);
    check_eq("add_latency1", 64'(out_valid), 64'd1);
    check_eq("add_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;

    // Back-to-back SUBs: the second request must be accepted immediately.
    send(4'h1, 8'h05, 8'h05, w);
    check_eq("sub1_wait", 64'(w), 64'd0);
    send(4'h1, 8'h03, 8'h04, w);
    check_eq("sub2_b2b_wait", 64'(w), 64'd0);

    // Logic ops and MUL overflow from a small table.
    send(4'h6, 8'hA5, 8'h0F, w);
    send(4'h7, 8'hA0, 8'h05, w);
    send(4'h8, 8'hFF, 8'hFF, w);
    send(4'h2, 8'h07, 8'h09, w);
    drain();

    // Random ops with random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(4'($urandom_range(0, 15)), 8'($urandom), (i % 5 == 0) ? 8'h00 : 8'($urandom), w);
    end
    drain();

    // DIV 200/7: busy for WIDTH cycles, and the result registers on the
    // WIDTH-th edge.
    send(4'h3, 8'd200, 8'd7, w);
    for (int k = 1; k <= W; k++) begin
      @(negedge clock);
      check_eq("div_busy", 64'({in_ready, out_valid}), 64'd0);
    end
    @(negedge clock);
    check_eq("div_done", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;

    // DIV by zero completes in one cycle.
    send(4'h3, 8'd9, 8'd0, w);
    @(negedge clock);
    check_eq("div0_latency1", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;
    drain();

    // MUL result held stable under a five-cycle stall.
    out_ready = 1'b0;
    send(4'h2, 8'h10, 8'h10, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("stall_hold", 64'({out_valid, in_ready, result, carry, zero, err}),
               64'({1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}));
    end
    @(posedge clock);
    #1;
    drain();

    // Reset in the middle of a divide.
    send(4'h3, 8'd200, 8'd7, w);
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("reset_mid_div", 64'({out_valid, result, carry, zero, err}), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("in_ready_after_mid_reset", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    send(4'h0, 8'h01, 8'h01, w);
    drain();

    // Unsupported code and the optional saturating codes.
    send(4'hF, 8'h12, 8'h34, w);
    send(4'h4, 8'hF0, 8'h20, w);
    send(4'h5, 8'h10, 8'h20, w);
    send(4'h4, 8'h10, 8'h20, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
